// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI-mode init sequencer.
package sd_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_BUSY  = 3'd2,
    ST_COLLECT    = 3'd3,
    ST_CHECK      = 3'd4,
    ST_RETRY_WAIT = 3'd5,
    ST_DONE       = 3'd6,
    ST_ERROR      = 3'd7
  } state_e;

  // Command currently being issued.
  typedef enum logic [2:0] {
    CMD_0   = 3'd0,
    CMD_8   = 3'd1,
    CMD_55  = 3'd2,
    CMD_A41 = 3'd3,
    CMD_58  = 3'd4
  } cmd_e;

  // Failure classes reported on error_code.
  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_CMD0   = 3'd1,
    ERR_CMD8   = 3'd2,
    ERR_ACMD41 = 3'd3,
    ERR_CMD58  = 3'd4,
    ERR_SPI    = 3'd5
  } err_e;

  // Full 48-bit command frames (start bits, index, argument, CRC7, stop bit).
  localparam logic [47:0] FRAME_CMD0   = 48'h400000000095;
  localparam logic [47:0] FRAME_CMD8   = 48'h48000001AA87;
  localparam logic [47:0] FRAME_CMD55  = 48'h770000000065;
  localparam logic [47:0] FRAME_ACMD41 = 48'h694000000077;
  localparam logic [47:0] FRAME_CMD58  = 48'h7A00000000FD;

  // Response lengths: R1 alone, or R1 followed by a 32-bit payload (R7/R3).
  localparam logic [9:0] BYTES_R1   = 10'd1;
  localparam logic [9:0] BYTES_LONG = 10'd5;

  localparam logic [7:0] R1_IDLE  = 8'h01;
  localparam logic [7:0] R1_READY = 8'h00;

  function automatic logic [47:0] cmd_frame(input cmd_e c);
    case (c)
      CMD_0:   return FRAME_CMD0;
      CMD_8:   return FRAME_CMD8;
      CMD_55:  return FRAME_CMD55;
      CMD_A41: return FRAME_ACMD41;
      default: return FRAME_CMD58;
    endcase
  endfunction

  function automatic logic [9:0] cmd_bytes(input cmd_e c);
    if (c == CMD_8 || c == CMD_58) return BYTES_LONG;
    return BYTES_R1;
  endfunction

endpackage

// File: rtl/sd_init_ctrl.sv
// SD-card SPI-mode initialisation sequencer: CMD0, CMD8, CMD55/ACMD41 polling,
// CMD58, then switches the SPI clock to fast speed and reports capacity class.
// Handshake with the SPI engine: spi_cmd is a one-cycle strobe issued only when
// spi_busy is low; the engine then raises spi_busy for the whole transaction,
// strobes each received byte with spi_avail, and drops spi_busy when finished.
module sd_init_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned CMD0_RETRIES   = 8,
  parameter int unsigned ACMD41_RETRIES = 1000,
  parameter int unsigned RETRY_WAIT     = 100
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        start,
  output logic [47:0] spi_cmd_data,
  output logic        spi_cmd,
  output logic [9:0]  spi_bytes_expected,
  input  logic        spi_busy,
  input  logic        spi_error,
  input  logic [7:0]  spi_response,
  input  logic        spi_avail,
  output logic        speed,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  error_code,
  output logic        card_sdhc,
  output state_e      dbg_state
);

  localparam int C0_W  = $clog2(CMD0_RETRIES + 1);
  localparam int A41_W = $clog2(ACMD41_RETRIES + 1);
  localparam int WT_W  = $clog2(RETRY_WAIT + 1);
  localparam logic [C0_W-1:0]  C0_MAX    = C0_W'(CMD0_RETRIES);
  localparam logic [A41_W-1:0] A41_MAX   = A41_W'(ACMD41_RETRIES);
  localparam logic [WT_W-1:0]  WAIT_LOAD = WT_W'(RETRY_WAIT - 1);

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic [47:0]       frame_q, frame_d;
  logic [9:0]        bytes_q, bytes_d;
  logic              spi_cmd_q, spi_cmd_d;
  logic [39:0]       cap_q, cap_d;
  logic [9:0]        byte_cnt_q, byte_cnt_d;
  logic              err_seen_q, err_seen_d;
  logic [C0_W-1:0]   c0_cnt_q, c0_cnt_d;
  logic [A41_W-1:0]  a41_cnt_q, a41_cnt_d;
  logic [WT_W-1:0]   wait_q, wait_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  err_e              code_q, code_d;
  logic              sdhc_q, sdhc_d;
  logic              speed_q, speed_d;
  logic              cmd_load;
  logic [7:0]        r1;
  logic              cap_unused;

  // Payload bytes 2..3 and the rest of the OCR carry nothing this block checks.
  assign cap_unused = ^{cap_q[31], cap_q[29:12]};

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_0;
      frame_q    <= '0;
      bytes_q    <= '0;
      spi_cmd_q  <= 1'b0;
      cap_q      <= '0;
      byte_cnt_q <= '0;
      err_seen_q <= 1'b0;
      c0_cnt_q   <= '0;
      a41_cnt_q  <= '0;
      wait_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= ERR_NONE;
      sdhc_q     <= 1'b0;
      speed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      frame_q    <= frame_d;
      bytes_q    <= bytes_d;
      spi_cmd_q  <= spi_cmd_d;
      cap_q      <= cap_d;
      byte_cnt_q <= byte_cnt_d;
      err_seen_q <= err_seen_d;
      c0_cnt_q   <= c0_cnt_d;
      a41_cnt_q  <= a41_cnt_d;
      wait_q     <= wait_d;
      done_q     <= done_d;
      error_q    <= error_d;
      code_q     <= code_d;
      sdhc_q     <= sdhc_d;
      speed_q    <= speed_d;
    end
  end

  // Next-state, response capture and response checking.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    frame_d    = frame_q;
    bytes_d    = bytes_q;
    spi_cmd_d  = 1'b0;
    cap_d      = cap_q;
    byte_cnt_d = byte_cnt_q;
    err_seen_d = err_seen_q;
    c0_cnt_d   = c0_cnt_q;
    a41_cnt_d  = a41_cnt_q;
    wait_d     = wait_q;
    done_d     = done_q;
    error_d    = error_q;
    code_d     = code_q;
    sdhc_d     = sdhc_q;
    speed_d    = speed_q;
    cmd_load   = 1'b0;
    // A short response sits in the low byte; a long one has R1 on top.
    r1 = (bytes_q == BYTES_LONG) ? cap_q[39:32] : cap_q[7:0];

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          code_d    = ERR_NONE;
          sdhc_d    = 1'b0;
          speed_d   = 1'b0;
          c0_cnt_d  = '0;
          a41_cnt_d = '0;
          cmd_d     = CMD_0;
          cmd_load  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!spi_busy) begin
          spi_cmd_d  = 1'b1;
          cap_d      = '0;
          byte_cnt_d = '0;
          err_seen_d = 1'b0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (spi_busy) begin
          if (spi_error) err_seen_d = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (spi_busy && spi_error) err_seen_d = 1'b1;
        // A byte arriving together with the falling busy still counts.
        if (spi_avail) begin
          cap_d = {cap_q[31:0], spi_response};
          if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 10'd1;
        end
        if (!spi_busy) begin
          if (err_seen_d || (byte_cnt_d != bytes_q)) begin
            state_d = ST_ERROR;
            code_d  = ERR_SPI;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_ERROR;
        case (cmd_q)
          CMD_0: begin
            if (c0_cnt_q != '1) c0_cnt_d = c0_cnt_q + 1'b1;
            if (r1 == R1_IDLE) begin
              cmd_d = CMD_8;  cmd_load = 1'b1; state_d = ST_ISSUE;
            end else if (c0_cnt_d < C0_MAX) begin
              cmd_load = 1'b1; state_d = ST_ISSUE;
            end else begin
              code_d = ERR_CMD0;
            end
          end
          CMD_8: begin
            if (r1 == R1_IDLE && cap_q[11:8] == 4'h1 && cap_q[7:0] == 8'hAA) begin
              cmd_d = CMD_55; cmd_load = 1'b1; state_d = ST_ISSUE;
            end else begin
              code_d = ERR_CMD8;
            end
          end
          CMD_55: begin
            if (r1 == R1_READY || r1 == R1_IDLE) begin
              cmd_d = CMD_A41; cmd_load = 1'b1; state_d = ST_ISSUE;
            end else begin
              code_d = ERR_ACMD41;
            end
          end
          CMD_A41: begin
            if (a41_cnt_q != '1) a41_cnt_d = a41_cnt_q + 1'b1;
            if (r1 == R1_READY) begin
              cmd_d = CMD_58; cmd_load = 1'b1; state_d = ST_ISSUE;
            end else if (r1 == R1_IDLE && a41_cnt_d < A41_MAX) begin
              cmd_d = CMD_55; cmd_load = 1'b1; wait_d = WAIT_LOAD;
              state_d = ST_RETRY_WAIT;
            end else begin
              code_d = ERR_ACMD41;
            end
          end
          default: begin
            if (r1 == R1_READY) begin
              sdhc_d  = cap_q[30];
              state_d = ST_DONE;
            end else begin
              code_d = ERR_CMD58;
            end
          end
        endcase
      end
      ST_RETRY_WAIT: begin
        if (wait_q == '0) state_d = ST_ISSUE;
        else wait_d = wait_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd_load) begin
      frame_d = cmd_frame(cmd_d);
      bytes_d = cmd_bytes(cmd_d);
    end
    // Status outputs rise in the same cycle the terminal state is entered.
    if (state_q != ST_DONE && state_d == ST_DONE) begin
      done_d  = 1'b1;
      speed_d = 1'b1;
    end
    if (state_q != ST_ERROR && state_d == ST_ERROR) begin
      error_d = 1'b1;
      speed_d = 1'b0;
    end
  end

  assign spi_cmd_data       = frame_q;
  assign spi_bytes_expected = bytes_q;
  assign spi_cmd            = spi_cmd_q;
  assign speed              = speed_q;
  assign init_done          = done_q;
  assign init_error         = error_q;
  assign error_code         = code_q;
  assign card_sdhc          = sdhc_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Directed bench for sd_init_ctrl with a behavioural SPI engine model.
module tb_sd_init_ctrl;
  import sd_pkg::*;

  localparam logic [47:0] F_CMD0   = 48'h400000000095;
  localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
  localparam logic [47:0] F_CMD55  = 48'h770000000065;
  localparam logic [47:0] F_ACMD41 = 48'h694000000077;
  localparam logic [47:0] F_CMD58  = 48'h7A00000000FD;

  localparam int M_NORMAL = 0, M_CMD0_FF = 1, M_V1 = 2, M_SHORT = 3, M_SPIERR = 4;

  // clock / reset
  logic clk = 1'b0;
  logic res_n, start;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] spi_cmd_data;
  logic        spi_cmd;
  logic [9:0]  spi_bytes_expected;
  logic        spi_busy, spi_error, spi_avail;
  logic [7:0]  spi_response;
  logic        speed, init_done, init_error, card_sdhc;
  logic [2:0]  error_code;
  state_e      dbg_state;

  sd_init_ctrl #(.CMD0_RETRIES(8), .ACMD41_RETRIES(4), .RETRY_WAIT(3)) dut (
    .clk(clk), .res_n(res_n), .start(start),
    .spi_cmd_data(spi_cmd_data), .spi_cmd(spi_cmd),
    .spi_bytes_expected(spi_bytes_expected),
    .spi_busy(spi_busy), .spi_error(spi_error),
    .spi_response(spi_response), .spi_avail(spi_avail),
    .speed(speed), .init_done(init_done), .init_error(init_error),
    .error_code(error_code), .card_sdhc(card_sdhc), .dbg_state(dbg_state)
  );

  // scenario knobs, written only by the main sequence
  int mode = M_NORMAL;
  int acmd_busy = 2;
  bit sdhc_card = 1'b1;
  bit stray_en = 1'b0;

  // engine-owned statistics
  int n_cmd = 0, n_cmd0 = 0, n_cmd8 = 0, n_cmd55 = 0, n_acmd41 = 0, n_cmd58 = 0;
  int n_unknown = 0, acmd_seen = 0, gap_cmd8 = -1, acmd_gaps = 0, acmd_gap_bad = 0;
  int last_fall = -100;
  bit prev_acmd = 1'b0;

  // SPI engine model: answers each strobed frame with the scenario's bytes.
  logic [47:0] frame;
  logic [7:0]  rb [5];
  int          nb, gap;
  bit          rerr;
  initial begin
    spi_busy = 0; spi_error = 0; spi_avail = 0; spi_response = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (res_n && spi_cmd === 1'b1) begin
        frame = spi_cmd_data;
        gap = cyc - last_fall;
        n_cmd++;
        rerr = 1'b0;
        nb = 1;
        rb[0] = 8'hFF; rb[1] = 8'h00; rb[2] = 8'h00; rb[3] = 8'h00; rb[4] = 8'h00;
        case (frame)
          F_CMD0: begin
            n_cmd0++; acmd_seen = 0;
            rb[0] = (mode == M_CMD0_FF) ? 8'hFF : 8'h01;
          end
          F_CMD8: begin
            n_cmd8++; gap_cmd8 = gap;
            nb = 5; rb[0] = 8'h01; rb[3] = 8'h01; rb[4] = 8'hAA;
            if (mode == M_V1) rb[0] = 8'h05;
            if (mode == M_SHORT) nb = 3;
            if (mode == M_SPIERR) rerr = 1'b1;
          end
          F_CMD55: begin
            n_cmd55++; rb[0] = 8'h01;
            if (prev_acmd) begin
              acmd_gaps++;
              if (gap != 5) acmd_gap_bad++;
            end
          end
          F_ACMD41: begin
            n_acmd41++;
            rb[0] = (acmd_seen < acmd_busy) ? 8'h01 : 8'h00;
            acmd_seen++;
          end
          F_CMD58: begin
            n_cmd58++; nb = 5;
            rb[0] = 8'h00; rb[1] = sdhc_card ? 8'hC0 : 8'h80;
            rb[2] = 8'hFF; rb[3] = 8'h80; rb[4] = 8'h00;
          end
          default: n_unknown++;
        endcase
        prev_acmd = (frame == F_ACMD41);
        @(negedge clk);
        spi_busy = 1; spi_error = rerr;
        for (int i = 0; i < nb; i++) begin
          @(negedge clk);
          if (!res_n) break;
          spi_response = rb[i]; spi_avail = 1;
          // last byte arrives in the same cycle busy falls
          if (i == nb - 1) begin
            spi_busy = 0; spi_error = 0; last_fall = cyc + 1;
          end
        end
        @(negedge clk);
        spi_busy = 0; spi_error = 0; spi_avail = 0;
        if (stray_en && res_n) begin
          spi_avail = 1; spi_response = 8'h00;
          @(negedge clk);
          spi_avail = 0;
        end
      end
    end
  end

  // protocol monitor on the strobe
  int dbl = 0, viol = 0;
  bit prev_cmd = 1'b0;
  always @(posedge clk) begin
    #1;
    if (spi_cmd && prev_cmd) dbl++;
    if (spi_cmd && spi_busy) viol++;
    prev_cmd = spi_cmd;
  end

  // scoreboard counters
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // driver tasks
  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done || init_error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int b_cmd, b0, b8, b55, b41, b58, b_gaps, b_gapbad;
  task automatic snap();
    b_cmd = n_cmd; b0 = n_cmd0; b8 = n_cmd8; b55 = n_cmd55;
    b41 = n_acmd41; b58 = n_cmd58; b_gaps = acmd_gaps; b_gapbad = acmd_gap_bad;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit ok, found;
  initial begin
    res_n = 0; start = 0;
    repeat (3) @(negedge clk);
    check("rst_done", init_done, 0);
    check("rst_error", init_error, 0);
    check("rst_code", error_code, 0);
    check("rst_sdhc", card_sdhc, 0);
    check("rst_speed", speed, 0);
    check("rst_cmd", spi_cmd, 0);
    check("rst_data", spi_cmd_data, 0);
    check("rst_bytes", spi_bytes_expected, 0);
    check("rst_state", dbg_state, ST_IDLE);
    res_n = 1;
    @(negedge clk);

    // nominal SDHC card, two busy ACMD41 rounds, stray bytes and stray start
    mode = M_NORMAL; acmd_busy = 2; sdhc_card = 1; stray_en = 1;
    snap();
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_end(2000, ok);
    check("nom_finished", ok, 1);
    check("nom_done", init_done, 1);
    check("nom_error", init_error, 0);
    check("nom_sdhc", card_sdhc, 1);
    check("nom_speed", speed, 1);
    check("nom_code", error_code, 0);
    check("nom_cmds", n_cmd - b_cmd, 9);
    check("nom_cmd0", n_cmd0 - b0, 1);
    check("nom_acmd41", n_acmd41 - b41, 3);
    check("nom_cmd8_gap", gap_cmd8, 2);
    check("nom_retry_gaps", acmd_gaps - b_gaps, 2);
    check("nom_retry_gap_bad", acmd_gap_bad - b_gapbad, 0);
    check("nom_data_held", spi_cmd_data, F_CMD58);
    check("nom_bytes_held", spi_bytes_expected, 5);
    stray_en = 0;

    // CMD0 never answers idle
    mode = M_CMD0_FF;
    snap();
    pulse_start();
    check("restart_done_clr", init_done, 0);
    check("restart_speed_clr", speed, 0);
    check("restart_sdhc_clr", card_sdhc, 0);
    wait_end(2000, ok);
    check("c0_finished", ok, 1);
    check("c0_error", init_error, 1);
    check("c0_code", error_code, 1);
    check("c0_strobes", n_cmd0 - b0, 8);
    check("c0_no_cmd8", n_cmd8 - b8, 0);
    check("c0_speed", speed, 0);

    // v1 card answers CMD8 with illegal command
    mode = M_V1;
    snap();
    pulse_start();
    wait_end(2000, ok);
    check("v1_finished", ok, 1);
    check("v1_error", init_error, 1);
    check("v1_code", error_code, 2);
    check("v1_no_cmd55", n_cmd55 - b55, 0);

    // ACMD41 stuck busy
    mode = M_NORMAL; acmd_busy = 1000;
    snap();
    pulse_start();
    wait_end(2000, ok);
    check("a41_finished", ok, 1);
    check("a41_error", init_error, 1);
    check("a41_code", error_code, 3);
    check("a41_cmd55", n_cmd55 - b55, 4);
    check("a41_acmd41", n_acmd41 - b41, 4);
    check("a41_gaps", acmd_gaps - b_gaps, 3);
    check("a41_gap_bad", acmd_gap_bad - b_gapbad, 0);
    check("a41_done", init_done, 0);

    // short CMD8 response
    mode = M_SHORT; acmd_busy = 2;
    snap();
    pulse_start();
    wait_end(2000, ok);
    check("short_finished", ok, 1);
    check("short_code", error_code, 5);
    check("short_speed", speed, 0);
    check("short_no_cmd55", n_cmd55 - b55, 0);

    // engine fault during CMD8
    mode = M_SPIERR;
    snap();
    pulse_start();
    wait_end(2000, ok);
    check("spierr_finished", ok, 1);
    check("spierr_error", init_error, 1);
    check("spierr_code", error_code, 5);
    check("spierr_speed", speed, 0);

    // reset during CMD58 collection, then a clean rerun with an SDSC card
    mode = M_NORMAL; acmd_busy = 2; sdhc_card = 1;
    snap();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #3;
      if (n_cmd58 > b58 && spi_busy) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_reached", found, 1);
    res_n = 0;
    #1;
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_error", init_error, 0);
    check("rst_mid_code", error_code, 0);
    check("rst_mid_cmd", spi_cmd, 0);
    check("rst_mid_data", spi_cmd_data, 0);
    check("rst_mid_bytes", spi_bytes_expected, 0);
    check("rst_mid_done", init_done, 0);
    repeat (3) @(negedge clk);
    res_n = 1;
    @(negedge clk);
    sdhc_card = 0;
    snap();
    pulse_start();
    wait_end(2000, ok);
    check("rerun_finished", ok, 1);
    check("rerun_done", init_done, 1);
    check("rerun_sdhc", card_sdhc, 0);
    check("rerun_speed", speed, 1);
    check("rerun_cmd0", n_cmd0 - b0, 1);
    check("rerun_cmds", n_cmd - b_cmd, 9);

    check("mon_double_strobe", dbl, 0);
    check("mon_strobe_busy", viol, 0);
    check("mon_unknown_frame", n_unknown, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
